// File: rtl/sarray_row_feeder.sv
// Left-edge injector for one systolic-array row: command, optional C preload, then K A beats.
// Build option: define SARRAY_FEEDER_SKEW_EN to insert the y-stage row skew line.
`ifndef SARRAY_W
`define SARRAY_W 4
`endif
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 2
`endif
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 16
`endif
`ifndef PE_DATA_TYPE_A
`define PE_DATA_TYPE_A 1'b0
`endif
`ifndef PE_DATA_TYPE_C
`define PE_DATA_TYPE_C 1'b1
`endif

module sarray_row_feeder #(
  parameter int y = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic                             cmd_load_c_i,
  input  logic [`TMMA_CNT_WIDTH-1:0]       cmd_k_i,
  input  logic [`TMMA_PRECISION_WIDTH-1:0] cmd_precision_i,
  input  logic                             c_valid_i,
  output logic                             c_ready_o,
  input  logic [`PE_INPUT_DATA_WIDTH-1:0]  c_data_i,
  input  logic                             a_valid_i,
  output logic                             a_ready_o,
  input  logic [`PE_INPUT_DATA_WIDTH-1:0]  a_data_i,
  output logic                             left_data_valid_o,
  output logic [`TMMA_CNT_WIDTH-1:0]       left_data_cnt_o,
  output logic                             left_data_type_o,
  output logic [`TMMA_PRECISION_WIDTH-1:0] left_precision_o,
  output logic [`PE_INPUT_DATA_WIDTH-1:0]  left_data_o,
  output logic                             done_o,
  output logic                             busy_o
);
  localparam int CW = `TMMA_CNT_WIDTH;
  localparam int PW = `TMMA_PRECISION_WIDTH;
  localparam int DW = `PE_INPUT_DATA_WIDTH;
  localparam int BW = 3 + CW + PW + DW;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD_C   = 2'd1;
  localparam logic [1:0] S_STREAM_A = 2'd2;

  localparam logic [CW-1:0] C_LAST = CW'(`SARRAY_W - 1);
  localparam logic [CW-1:0] C_TOP  = CW'(`SARRAY_W);
  localparam logic [CW-1:0] ONE    = CW'(1);

`ifdef SARRAY_FEEDER_SKEW_EN
  localparam bit SKEW_ON = 1'b1;
`else
  localparam bit SKEW_ON = 1'b0;
`endif

  logic [1:0]    r_state;
  logic [CW-1:0] r_k;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_prec;

  logic          r_vld_p0;
  logic          r_done_p0;
  logic          r_type_p0;
  logic [CW-1:0] r_cnt_p0;
  logic [PW-1:0] r_prec_p0;
  logic [DW-1:0] r_data_p0;

  logic          w_cmd_hs;
  logic          w_c_hs;
  logic          w_a_hs;
  logic          w_c_last;
  logic          w_a_last;
  logic          w_done;
  logic [BW-1:0] w_p0;
  logic [BW-1:0] w_out;

  assign w_cmd_hs = (r_state == S_IDLE) && cmd_valid_i;
  assign w_c_hs   = (r_state == S_LOAD_C) && c_valid_i;
  assign w_a_hs   = (r_state == S_STREAM_A) && a_valid_i;
  assign w_c_last = w_c_hs && (r_cnt == C_LAST);
  assign w_a_last = w_a_hs && (r_cnt == (r_k - ONE));
  // A command ends on its last beat, or immediately when it carries no beats at all.
  assign w_done   = (w_cmd_hs && !cmd_load_c_i && (cmd_k_i == '0)) ||
                    (w_c_last && (r_k == '0)) || w_a_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_prec  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_k    <= cmd_k_i;
            r_prec <= cmd_precision_i;
            r_cnt  <= '0;
            if (cmd_load_c_i)        r_state <= S_LOAD_C;
            else if (cmd_k_i != '0) r_state <= S_STREAM_A;
          end
        end
        S_LOAD_C: begin
          if (w_c_last) begin
            r_cnt   <= '0;
            r_state <= (r_k != '0) ? S_STREAM_A : S_IDLE;
          end else if (w_c_hs) begin
            r_cnt <= r_cnt + ONE;
          end
        end
        S_STREAM_A: begin
          if (w_a_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_a_hs) begin
            r_cnt <= r_cnt + ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---- stage 0: tag the accepted beat; bubbles keep the previous fields ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0  <= 1'b0;
      r_done_p0 <= 1'b0;
      r_type_p0 <= 1'b0;
      r_cnt_p0  <= '0;
      r_prec_p0 <= '0;
      r_data_p0 <= '0;
    end else begin
      r_vld_p0  <= w_c_hs || w_a_hs;
      r_done_p0 <= w_done;
      if (w_c_hs) begin
        r_type_p0 <= `PE_DATA_TYPE_C;
        r_cnt_p0  <= C_TOP - r_cnt;
        r_prec_p0 <= r_prec;
        r_data_p0 <= c_data_i;
      end else if (w_a_hs) begin
        r_type_p0 <= `PE_DATA_TYPE_A;
        r_cnt_p0  <= r_cnt;
        r_prec_p0 <= r_prec;
        r_data_p0 <= a_data_i;
      end
    end
  end

  assign w_p0 = {r_vld_p0, r_done_p0, r_type_p0, r_cnt_p0, r_prec_p0, r_data_p0};

  // ---- skew line: row y lags row 0 by y cycles, advancing every cycle ----
  if (SKEW_ON && (y > 0)) begin : g_skew
    logic [BW-1:0] r_beat_pn [y];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < y; i++) r_beat_pn[i] <= '0;
      end else begin
        r_beat_pn[0] <= w_p0;
        for (int i = 1; i < y; i++) r_beat_pn[i] <= r_beat_pn[i-1];
      end
    end
    assign w_out = r_beat_pn[y-1];
  end else begin : g_direct
    assign w_out = w_p0;
  end

  assign {left_data_valid_o, done_o, left_data_type_o, left_data_cnt_o,
          left_precision_o, left_data_o} = w_out;

  assign cmd_ready_o = rst_n && (r_state == S_IDLE);
  assign c_ready_o   = (r_state == S_LOAD_C);
  assign a_ready_o   = (r_state == S_STREAM_A);
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sarray_row_feeder.sv
// Directed bench for sarray_row_feeder (row y=2); expected stage-0 beats are delayed by the skew depth.
`timescale 1ns/1ps
`ifndef SARRAY_W
`define SARRAY_W 4
`endif
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 2
`endif
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 16
`endif
`ifndef PE_DATA_TYPE_A
`define PE_DATA_TYPE_A 1'b0
`endif
`ifndef PE_DATA_TYPE_C
`define PE_DATA_TYPE_C 1'b1
`endif

module tb_sarray_row_feeder;
  localparam int CW = `TMMA_CNT_WIDTH;
  localparam int PW = `TMMA_PRECISION_WIDTH;
  localparam int DW = `PE_INPUT_DATA_WIDTH;
  localparam int Y  = 2;
`ifdef SARRAY_FEEDER_SKEW_EN
  localparam int D = Y;
`else
  localparam int D = 0;
`endif
  localparam int TC = int'(`PE_DATA_TYPE_C);
  localparam int TA = int'(`PE_DATA_TYPE_A);

  typedef struct packed {
    logic          vld;
    logic          done;
    logic          typ;
    logic [CW-1:0] cnt;
    logic [PW-1:0] prec;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_load_c;
  logic [CW-1:0] cmd_k;
  logic [PW-1:0] cmd_prec;
  logic          c_valid, c_ready;
  logic [DW-1:0] c_data;
  logic          a_valid, a_ready;
  logic [DW-1:0] a_data;
  logic          l_valid, l_type, done, busy;
  logic [CW-1:0] l_cnt;
  logic [PW-1:0] l_prec;
  logic [DW-1:0] l_data;

  int    total = 0;
  int    bad   = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  sarray_row_feeder #(.y(Y)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_load_c_i(cmd_load_c),
    .cmd_k_i(cmd_k), .cmd_precision_i(cmd_prec),
    .c_valid_i(c_valid), .c_ready_o(c_ready), .c_data_i(c_data),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
    .left_data_valid_o(l_valid), .left_data_cnt_o(l_cnt), .left_data_type_o(l_type),
    .left_precision_o(l_prec), .left_data_o(l_data),
    .done_o(done), .busy_o(busy)
  );

  function automatic beat_t mk(int v, int dn, int t, int c, int p, int d);
    beat_t b;
    b.vld = 1'(v); b.done = 1'(dn); b.typ = 1'(t);
    b.cnt = CW'(c); b.prec = PW'(p); b.data = DW'(d);
    return b;
  endfunction

  localparam beat_t BUB = '0;

  task automatic ck(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic reset_q();
    q.delete();
    for (int i = 0; i < D; i++) q.push_back(BUB);
  endtask

  // One clock edge: queue the stage-0 beat expected at this edge, check the beat due at the output.
  task automatic tick(input string tag, input beat_t e0);
    beat_t o, e;
    @(posedge clk); #1;
    q.push_back(e0);
    e = q.pop_front();
    o = {l_valid, done, l_type, l_cnt, l_prec, l_data};
    if (!e.vld) begin
      o.typ = 1'b0; o.cnt = '0; o.prec = '0; o.data = '0;
    end
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load_c = 1'b0; cmd_k = '0; cmd_prec = '0;
    c_valid = 1'b0; c_data = '0; a_valid = 1'b0; a_data = '0;

    @(posedge clk); #1;
    ck("rst_cmd_ready", 32'(cmd_ready), 0);
    ck("rst_valid", 32'(l_valid), 0);
    ck("rst_done", 32'(done), 0);
    ck("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_q();
    #1;
    ck("post_rst_cmd_ready", 32'(cmd_ready), 1);
    ck("post_rst_c_ready", 32'(c_ready), 0);
    ck("post_rst_a_ready", 32'(a_ready), 0);

    // Full command: 4 C words then 3 A words, precision 2.
    cmd_valid = 1'b1; cmd_load_c = 1'b1; cmd_k = 8'd3; cmd_prec = 2'd2;
    tick("full_cmd", BUB);
    cmd_valid = 1'b0;
    ck("full_c_ready", 32'(c_ready), 1);
    ck("full_cmd_ready", 32'(cmd_ready), 0);
    ck("full_a_ready_in_c", 32'(a_ready), 0);
    ck("full_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      c_valid = 1'b1; c_data = DW'(10 + i);
      tick("full_c", mk(1, 0, TC, 4 - i, 2, 10 + i));
    end
    c_valid = 1'b0;
    ck("full_a_ready", 32'(a_ready), 1);
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_data = DW'(20 + i);
      tick("full_a", mk(1, (i == 2) ? 1 : 0, TA, i, 2, 20 + i));
    end
    a_valid = 1'b0;
    ck("full_end_cmd_ready", 32'(cmd_ready), 1);
    ck("full_end_busy", 32'(busy), 0);
    repeat (D + 1) tick("full_drain", BUB);

    // Stalled A stream; foreign handshakes during the stall are ignored.
    cmd_valid = 1'b1; cmd_load_c = 1'b0; cmd_k = 8'd3; cmd_prec = 2'd1;
    tick("stall_cmd", BUB);
    cmd_valid = 1'b0;
    a_valid = 1'b1; a_data = 16'd30;
    tick("stall_a0", mk(1, 0, TA, 0, 1, 30));
    a_valid = 1'b0; c_valid = 1'b1; c_data = 16'd99; cmd_valid = 1'b1; cmd_k = '0;
    repeat (2) tick("stall_bubble", BUB);
    ck("stall_cmd_ready", 32'(cmd_ready), 0);
    c_valid = 1'b0; cmd_valid = 1'b0;
    a_valid = 1'b1; a_data = 16'd31;
    tick("stall_a1", mk(1, 0, TA, 1, 1, 31));
    a_data = 16'd32;
    tick("stall_a2", mk(1, 1, TA, 2, 1, 32));
    a_valid = 1'b0;

    // Empty command straight after, then a C-only command back to back.
    cmd_valid = 1'b1; cmd_load_c = 1'b0; cmd_k = '0; cmd_prec = 2'd0;
    tick("empty_cmd", mk(0, 1, 0, 0, 0, 0));
    ck("empty_cmd_ready", 32'(cmd_ready), 1);
    ck("empty_busy", 32'(busy), 0);
    cmd_load_c = 1'b1; cmd_prec = 2'd3;
    tick("conly_cmd", BUB);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_valid = 1'b1; c_data = DW'(40 + i); a_valid = 1'b1; a_data = 16'd77;
      tick("conly_c", mk(1, (i == 3) ? 1 : 0, TC, 4 - i, 3, 40 + i));
      ck("conly_a_ready", 32'(a_ready), 0);
    end
    c_valid = 1'b0; a_valid = 1'b0;
    ck("conly_cmd_ready", 32'(cmd_ready), 1);
    repeat (D + 1) tick("conly_drain", BUB);

    // Reset in the middle of a C burst.
    cmd_valid = 1'b1; cmd_load_c = 1'b1; cmd_k = 8'd4; cmd_prec = 2'd1;
    tick("rmb_cmd", BUB);
    cmd_valid = 1'b0;
    c_valid = 1'b1; c_data = 16'd50;
    tick("rmb_c0", mk(1, 0, TC, 4, 1, 50));
    c_data = 16'd51;
    tick("rmb_c1", mk(1, 0, TC, 3, 1, 51));
    c_valid = 1'b0;
    tick("rmb_stall", BUB);
    #2 rst_n = 1'b0;
    #1;
    ck("rmb_valid", 32'(l_valid), 0);
    ck("rmb_done", 32'(done), 0);
    ck("rmb_cnt", 32'(l_cnt), 0);
    ck("rmb_data", 32'(l_data), 0);
    ck("rmb_type", 32'(l_type), 0);
    ck("rmb_prec", 32'(l_prec), 0);
    ck("rmb_cmd_ready", 32'(cmd_ready), 0);
    ck("rmb_c_ready", 32'(c_ready), 0);
    ck("rmb_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_q();
    #1;
    ck("rmb_rel_cmd_ready", 32'(cmd_ready), 1);
    repeat (D + 1) tick("rmb_no_done", BUB);
    cmd_valid = 1'b1; cmd_load_c = 1'b0; cmd_k = 8'd1; cmd_prec = 2'd2;
    tick("rmb_new_cmd", BUB);
    cmd_valid = 1'b0;
    a_valid = 1'b1; a_data = 16'd60;
    tick("rmb_new_a", mk(1, 1, TA, 0, 2, 60));
    a_valid = 1'b0;
    repeat (D + 1) tick("rmb_drain", BUB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
